// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the sequential nibble ALU.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned STEPS_ADDSUB = 1;
  localparam int unsigned STEPS_MULDIV = 4;

  localparam logic [3:0] DIVZ_Q = 4'hF;
  localparam logic [3:0] DIVZ_T = 4'hE;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/alu_iter_step.sv
// One iteration of the multiply (shift-add) or divide (restoring) datapath.
module alu_iter_step (
  input  logic       is_div,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] idx,
  input  logic [7:0] acc,
  input  logic [4:0] rem,
  input  logic [3:0] quo,
  output logic [7:0] acc_next,
  output logic [4:0] rem_next,
  output logic [3:0] quo_next
);

  logic [7:0] partial;
  logic [4:0] rem_sh;
  logic [1:0] div_idx;
  logic       qbit;

  always_comb begin
    partial  = b[idx] ? ({4'b0000, a} << idx) : 8'h00;
    // Divide consumes dividend bits MSB first.
    div_idx  = 2'd3 - idx;
    rem_sh   = {rem[3:0], a[div_idx]};
    qbit     = (rem_sh >= {1'b0, b});
    acc_next = acc;
    rem_next = rem;
    quo_next = quo;
    if (is_div) begin
      rem_next = qbit ? (rem_sh - {1'b0, b}) : rem_sh;
      quo_next = {quo[2:0], qbit};
    end else begin
      acc_next = acc + partial;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle 4-bit add/sub/mul/div unit feeding the Q/S/T digit decoders.
module alu_seq_unit
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  input  logic       start,
  output logic       busy,
  output logic       read,
  output logic [3:0] q,
  output logic [3:0] s,
  output logic [3:0] t
);

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [1:0] op_q, op_d, cnt_q, cnt_d, last_cnt;
  logic [7:0] acc_q, acc_d, acc_step;
  logic [4:0] rem_q, rem_d, rem_step;
  logic [3:0] quo_q, quo_d, quo_step;
  logic [3:0] q_q, q_d, s_q, s_d, t_q, t_d;
  logic [4:0] sum;

  alu_iter_step u_step (
    .is_div   (op_q == OP_DIV),
    .a        (a_q),
    .b        (b_q),
    .idx      (cnt_q),
    .acc      (acc_q),
    .rem      (rem_q),
    .quo      (quo_q),
    .acc_next (acc_step),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    q_d      = q_q;
    s_d      = s_q;
    t_d      = t_q;
    sum      = {1'b0, a_q} + {1'b0, b_q};
    last_cnt = op_q[1] ? 2'(STEPS_MULDIV - 1) : 2'(STEPS_ADDSUB - 1);
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StCalc;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = 2'd0;
          acc_d   = 8'h00;
          rem_d   = 5'h00;
          quo_d   = 4'h0;
        end
      end
      StCalc: begin
        acc_d = acc_step;
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_cnt) begin
          state_d = StDone;
          unique case (op_q)
            OP_ADD: begin
              q_d = 4'h0;
              s_d = sum[3:0];
              t_d = {3'b000, sum[4]};
            end
            OP_SUB: begin
              q_d = 4'h0;
              s_d = a_q - b_q;
              t_d = {3'b000, (a_q < b_q)};
            end
            OP_MUL: begin
              q_d = 4'h0;
              s_d = acc_step[3:0];
              t_d = acc_step[7:4];
            end
            default: begin
              // Divide by zero still runs all steps; the result is forced here.
              if (b_q == 4'h0) begin
                q_d = DIVZ_Q;
                s_d = a_q;
                t_d = DIVZ_T;
              end else begin
                q_d = quo_step;
                s_d = rem_step[3:0];
                t_d = 4'h0;
              end
            end
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      op_q    <= 2'b00;
      cnt_q   <= 2'd0;
      acc_q   <= 8'h00;
      rem_q   <= 5'h00;
      quo_q   <= 4'h0;
      q_q     <= 4'h0;
      s_q     <= 4'h0;
      t_q     <= 4'h0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      s_q     <= s_d;
      t_q     <= t_d;
    end
  end

  assign busy = (state_q == StCalc);
  assign read = (state_q == StDone);
  assign q    = q_q;
  assign s    = s_q;
  assign t    = t_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed scoreboard bench for alu_seq_unit.
module tb_alu_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic [1:0] op;
  logic       start;
  logic       busy, read;
  logic [3:0] q, s, t;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] s;
    logic [3:0] t;
  } res_t;

  res_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  alu_seq_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .start (start),
    .busy  (busy),
    .read  (read),
    .q     (q),
    .s     (s),
    .t     (t)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
    res_t r;
    int   v;
    r = '0;
    case (o)
      2'b00: begin
        v = int'(x) + int'(y);
        r.s = v[3:0];
        r.t = (v > 15) ? 4'h1 : 4'h0;
      end
      2'b01: begin
        v = int'(x) - int'(y) + 16;
        r.s = v[3:0];
        r.t = (x < y) ? 4'h1 : 4'h0;
      end
      2'b10: begin
        v = int'(x) * int'(y);
        r.s = v[3:0];
        r.t = v[7:4];
      end
      default: begin
        if (y == 4'h0) begin
          r.q = 4'hF;
          r.s = x;
          r.t = 4'hE;
        end else begin
          v = int'(x) / int'(y);
          r.q = v[3:0];
          v = int'(x) % int'(y);
          r.s = v[3:0];
        end
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_q"}, {28'd0, q}, {28'd0, e.q});
    chk({tag, "_s"}, {28'd0, s}, {28'd0, e.s});
    chk({tag, "_t"}, {28'd0, t}, {28'd0, e.t});
  endtask

  // Issue one operation, wait (bounded) for read, compare latency and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] x,
                        input logic [3:0] y);
    int n;
    int lat;
    a = x; b = y; op = o; start = 1'b1;
    sb.push_back(model(o, x, y));
    tick();
    start = 1'b0;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_read_e0"}, {31'd0, read}, 32'd0);
    lat = o[1] ? 4 : 1;
    n = 0;
    while (!read && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    pop_check(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0; op = 2'b00;
    #12;
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_qst", {20'd0, q, s, t}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_read", {31'd0, read}, 32'd0);

    run_op("add98", 2'b00, 4'h9, 4'h8);
    run_op("sub35", 2'b01, 4'h3, 4'h5);
    run_op("mul7d", 2'b10, 4'h7, 4'hD);
    run_op("divd4", 2'b11, 4'hD, 4'h4);
    run_op("div60", 2'b11, 4'h6, 4'h0);
    run_op("addff", 2'b00, 4'hF, 4'hF);
    run_op("sub00", 2'b01, 4'h0, 4'h0);
    run_op("mulff", 2'b10, 4'hF, 4'hF);
    run_op("divf1", 2'b11, 4'hF, 4'h1);
    run_op("div3f", 2'b11, 4'h3, 4'hF);

    // mul 7*D with a start/add request and operand churn mid-calculation
    a = 4'h7; b = 4'hD; op = 2'b10; start = 1'b1;
    sb.push_back(model(2'b10, 4'h7, 4'hD));
    tick();
    start = 1'b0;
    a = 4'h1; b = 4'h1; op = 2'b00;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy_e2", {31'd0, busy}, 32'd1);
    chk("ign_read_e2", {31'd0, read}, 32'd0);
    tick();
    chk("ign_read_e3", {31'd0, read}, 32'd0);
    tick();
    chk("ign_read_e4", {31'd0, read}, 32'd1);
    pop_check("ign_mul");
    tick();
    chk("hold_read", {31'd0, read}, 32'd1);
    chk("hold_qst", {20'd0, q, s, t}, {20'd0, 4'h0, 4'hB, 4'h5});

    // start held high: one-cycle read pulse per result
    a = 4'h2; b = 4'h3; op = 2'b00; start = 1'b1;
    sb.push_back(model(2'b00, 4'h2, 4'h3));
    sb.push_back(model(2'b00, 4'h2, 4'h3));
    tick();
    chk("cont_busy_e0", {31'd0, busy}, 32'd1);
    tick();
    chk("cont_read_e1", {31'd0, read}, 32'd1);
    pop_check("cont1");
    tick();
    chk("cont_read_e2", {31'd0, read}, 32'd0);
    chk("cont_busy_e2", {31'd0, busy}, 32'd1);
    tick();
    chk("cont_read_e3", {31'd0, read}, 32'd1);
    pop_check("cont2");
    start = 1'b0;
    tick();

    // reset mid-division discards everything immediately
    a = 4'hD; b = 4'h3; op = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_qst", {20'd0, q, s, t}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_read", {31'd0, read}, 32'd0);
    #4;
    rst_n = 1'b1;
    tick();
    chk("post_rst_read", {31'd0, read}, 32'd0);
    run_op("add11", 2'b00, 4'h1, 4'h1);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
